equiv_vector_sequencer: RTL and testbench

//  Self-contained stimulus scheduler for netlist equivalence runs. Drives one packed input

---
 rtl/equiv_vector_sequencer.sv | 136 +++++++++++++
 tb/tb_equiv_vector_sequencer.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/equiv_vector_sequencer.sv
// Purpose : on-chip stimulus sequencer and output checker for netlist equivalence runs.
// Latency : one vector every SETTLE_CYC+1 cycles; done rises NUM_VEC*(SETTLE_CYC+1) cycles after start.
// Backpres: none; start is ignored while busy, and abort always wins and returns to IDLE.
// Ports   : clk/rst_n (async active-low); start/abort/seed_load/seed_in control;
//           stim/stim_valid/vec_idx drive both netlists; y_ref/y_dut are compared;
//           busy/done/fail/mismatch_cnt/first_fail_idx report run status and results.
module equiv_vector_sequencer #(
  parameter int          IN_W       = 52,
  parameter int          OUT_W      = 924,
  parameter int          NUM_VEC    = 21,
  parameter int          SETTLE_CYC = 1,
  parameter logic [63:0] SEED       = 64'h1,
  parameter int          CNT_W      = 8,
  parameter int          IDX_W      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             seed_load,
  input  logic [63:0]      seed_in,
  output logic [IN_W-1:0]  stim,
  output logic             stim_valid,
  input  logic [OUT_W-1:0] y_ref,
  input  logic [OUT_W-1:0] y_dut,
  output logic             busy,
  output logic             done,
  output logic             fail,
  output logic [CNT_W-1:0] mismatch_cnt,
  output logic [IDX_W-1:0] first_fail_idx,
  output logic [IDX_W-1:0] vec_idx
);

  typedef enum logic [1:0] {IDLE, SETTLE, COMPARE, DONE} state_t;

  localparam logic [63:0]      TAPS        = 64'hD800_0000_0000_0000;
  localparam int               SC_W        = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [SC_W-1:0]  SETTLE_LAST = SC_W'(SETTLE_CYC - 1);
  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(NUM_VEC - 1);

  state_t            state, state_nxt;
  logic [SC_W-1:0]   settle_cnt;
  logic [63:0]       lfsr;
  logic [63:0]       seed_reg;

  logic              idle_like;
  logic              start_ok;
  logic              load_seed;
  logic              last_vec;
  logic              settle_done;
  logic              mismatch;
  logic [63:0]       seed_eff;
  logic [63:0]       seed_now;
  logic [63:0]       lfsr_step;

  assign idle_like   = (state == IDLE) || (state == DONE);
  assign start_ok    = start && !abort && idle_like;
  assign load_seed   = seed_load && idle_like;
  assign last_vec    = (vec_idx == LAST_IDX);
  assign settle_done = (settle_cnt == SETTLE_LAST);
  assign mismatch    = (y_ref != y_dut);

  // A zero seed would lock the LFSR at zero, so it is replaced by SEED.
  assign seed_eff  = (seed_in == 64'd0) ? SEED : seed_in;
  // A seed loaded on the same edge as start is the one used for that run.
  assign seed_now  = load_seed ? seed_eff : seed_reg;
  assign lfsr_step = {1'b0, lfsr[63:1]} ^ (lfsr[0] ? TAPS : 64'd0);

  assign busy       = (state == SETTLE) || (state == COMPARE);
  assign stim_valid = busy;
  assign done       = (state == DONE);
  assign fail       = (mismatch_cnt != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE, DONE: if (start) state_nxt = SETTLE;
        SETTLE:     if (settle_done) state_nxt = COMPARE;
        COMPARE:    state_nxt = last_vec ? DONE : SETTLE;
        default:    state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seed_reg       <= SEED;
      lfsr           <= SEED;
      stim           <= '0;
      vec_idx        <= '0;
      mismatch_cnt   <= '0;
      first_fail_idx <= '1;
      settle_cnt     <= '0;
    end else begin
      if (load_seed) begin
        seed_reg <= seed_eff;
      end
      // Abort freezes every result and discards any compare in flight.
      if (!abort) begin
        if (start_ok) begin
          lfsr           <= seed_now;
          stim           <= '0;
          vec_idx        <= '0;
          mismatch_cnt   <= '0;
          first_fail_idx <= '1;
          settle_cnt     <= '0;
        end else if (state == SETTLE) begin
          settle_cnt <= settle_done ? '0 : settle_cnt + 1'b1;
        end else if (state == COMPARE) begin
          if (mismatch) begin
            if (mismatch_cnt != '1) mismatch_cnt <= mismatch_cnt + 1'b1;
            if (first_fail_idx == '1) first_fail_idx <= vec_idx;
          end
          // Vector 0 is all-zero; vector n>0 is the top slice of the n-th LFSR step.
          if (!last_vec) begin
            lfsr    <= lfsr_step;
            stim    <= lfsr_step[63 -: IN_W];
            vec_idx <= vec_idx + 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_equiv_vector_sequencer.sv
module tb_equiv_vector_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n, start, abort, seed_load, start_b;
  logic [63:0]  seed_in;
  logic [923:0] y_ref, y_dut, y_dut_b;
  int           flip_idx;

  logic [51:0]  stim, stim_b;
  logic         stim_valid, busy, done, fail;
  logic [7:0]   mismatch_cnt, first_fail_idx, vec_idx;
  logic         stim_valid_b, busy_b, done_b, fail_b;
  logic [1:0]   mismatch_cnt_b;
  logic [7:0]   first_fail_idx_b, vec_idx_b;

  assign y_ref   = {40'hA5_C30F_1E77, {17{stim}}};
  assign y_dut_b = ~y_ref;

  always_comb begin
    y_dut = y_ref;
    if (flip_idx >= 0 && vec_idx == 8'(flip_idx)) y_dut[923] = ~y_ref[923];
  end

  equiv_vector_sequencer #(.NUM_VEC(4), .SETTLE_CYC(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .seed_load(seed_load), .seed_in(seed_in),
    .stim(stim), .stim_valid(stim_valid), .y_ref(y_ref), .y_dut(y_dut),
    .busy(busy), .done(done), .fail(fail), .mismatch_cnt(mismatch_cnt),
    .first_fail_idx(first_fail_idx), .vec_idx(vec_idx)
  );

  equiv_vector_sequencer #(.NUM_VEC(6), .SETTLE_CYC(1), .CNT_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .abort(1'b0),
    .seed_load(1'b0), .seed_in(64'd0),
    .stim(stim_b), .stim_valid(stim_valid_b), .y_ref(y_ref), .y_dut(y_dut_b),
    .busy(busy_b), .done(done_b), .fail(fail_b), .mismatch_cnt(mismatch_cnt_b),
    .first_fail_idx(first_fail_idx_b), .vec_idx(vec_idx_b)
  );

  typedef struct {
    logic [51:0] stim;
    logic [7:0]  idx;
    logic        sv;
    logic        busy;
    logic        done;
  } obs_t;

  obs_t tbl[9];
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Start a run on the sequencer under test and check every cycle against the table.
  task automatic run_table(input string tag);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 9; k++) begin
      check($sformatf("%s_cyc%0d", tag, k),
            {stim, vec_idx, stim_valid, busy, done},
            {tbl[k].stim, tbl[k].idx, tbl[k].sv, tbl[k].busy, tbl[k].done});
      if (k != 8) tick();
    end
  endtask

  task automatic check_res(input string tag, input logic [7:0] cnt, input logic [7:0] ffi,
                           input logic fl);
    check({tag, "_cnt"}, mismatch_cnt, cnt);
    check({tag, "_ffi"}, first_fail_idx, ffi);
    check({tag, "_fail"}, fail, fl);
  endtask

  task automatic check_flags(input string tag);
    check({tag, "_flags"}, {stim_valid, busy, done}, 3'b000);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; seed_load = 1'b0;
    seed_in = 64'd0; start_b = 1'b0; flip_idx = -1;

    tbl[0] = '{52'h0,               8'd0, 1'b1, 1'b1, 1'b0};
    tbl[1] = '{52'h0,               8'd0, 1'b1, 1'b1, 1'b0};
    tbl[2] = '{52'hD_8000_0000_0000, 8'd1, 1'b1, 1'b1, 1'b0};
    tbl[3] = '{52'hD_8000_0000_0000, 8'd1, 1'b1, 1'b1, 1'b0};
    tbl[4] = '{52'h6_C000_0000_0000, 8'd2, 1'b1, 1'b1, 1'b0};
    tbl[5] = '{52'h6_C000_0000_0000, 8'd2, 1'b1, 1'b1, 1'b0};
    tbl[6] = '{52'h3_6000_0000_0000, 8'd3, 1'b1, 1'b1, 1'b0};
    tbl[7] = '{52'h3_6000_0000_0000, 8'd3, 1'b1, 1'b1, 1'b0};
    tbl[8] = '{52'h3_6000_0000_0000, 8'd3, 1'b0, 1'b0, 1'b1};

    // Reset values.
    #12;
    check("reset_outs", {stim, vec_idx, stim_valid, busy, done, mismatch_cnt, fail}, '0);
    check("reset_ffi", first_fail_idx, 8'hFF);
    rst_n = 1'b1;
    tick();

    // Clean run.
    run_table("t1");
    check_res("t1", 8'd0, 8'hFF, 1'b0);

    // Single mismatch on vector 2.
    flip_idx = 2;
    run_table("t2");
    check_res("t2", 8'd1, 8'd2, 1'b1);
    flip_idx = -1;

    // Saturating counter on the 2-bit instance, every vector failing.
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    repeat (11) tick();
    check("t3_done_early", done_b, 1'b0);
    tick();
    check("t3_done", {done_b, busy_b, stim_valid_b}, 3'b100);
    check("t3_cnt", mismatch_cnt_b, 2'b11);
    check("t3_ffi", first_fail_idx_b, 8'd0);
    check("t3_fail", fail_b, 1'b1);

    // Abort in SETTLE of vector 1: results from vector 0 hold.
    flip_idx = 0;
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick();
    check("t4_pre_abort_idx", vec_idx, 8'd1);
    abort = 1'b1; tick(); abort = 1'b0;
    check_flags("t4_abort");
    check_res("t4_abort", 8'd1, 8'd0, 1'b1);

    // Abort wins over start in IDLE.
    start = 1'b1; abort = 1'b1; tick(); start = 1'b0; abort = 1'b0;
    check_flags("t4_prio");
    check_res("t4_prio", 8'd1, 8'd0, 1'b1);

    // Abort during COMPARE of a failing vector discards that compare.
    start = 1'b1; tick(); start = 1'b0;
    tick();
    abort = 1'b1; tick(); abort = 1'b0;
    check_flags("t4_abort_cmp");
    check_res("t4_abort_cmp", 8'd0, 8'hFF, 1'b0);
    flip_idx = -1;
    run_table("t4_restart");
    check_res("t4_restart", 8'd0, 8'hFF, 1'b0);

    // Asynchronous reset in the middle of a SETTLE cycle.
    flip_idx = 0;
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick();
    #2 rst_n = 1'b0;
    #1;
    check("t5_async_outs", {stim, vec_idx, stim_valid, busy, done, mismatch_cnt, fail}, '0);
    check("t5_async_ffi", first_fail_idx, 8'hFF);
    flip_idx = -1;
    #2 rst_n = 1'b1;
    tick();
    run_table("t5");
    check_res("t5", 8'd0, 8'hFF, 1'b0);

    // Seed loaded together with start is used for that run.
    seed_in = 64'h8000_0000_0000_0000;
    seed_load = 1'b1; start = 1'b1; tick(); seed_load = 1'b0; start = 1'b0;
    tick(); tick();
    check("t6_seed_stim1", stim, 52'h4_0000_0000_0000);
    // Seed load while busy is ignored.
    seed_in = 64'h1;
    seed_load = 1'b1; tick(); seed_load = 1'b0;
    repeat (5) tick();
    check("t6_done", done, 1'b1);
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick();
    check("t6_seed_kept", stim, 52'h4_0000_0000_0000);
    repeat (6) tick();
    check("t6_done2", done, 1'b1);
    // Zero seed falls back to SEED.
    seed_in = 64'd0;
    seed_load = 1'b1; tick(); seed_load = 1'b0;
    run_table("t6_zero");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
